// File: rtl/fifo_axi_drain.sv
// Drains {addr, line} entries from a show-ahead FIFO into single AXI4 INCR write bursts.
// One transaction is in flight at a time; a non-OKAY write response sets a sticky error flag.
module fifo_axi_drain #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 128,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID         = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fifo_empty,
  input  logic [ADDR_WIDTH+LINE_WIDTH-1:0] fifo_data,
  output logic                           fifo_pop,
  output logic                           awvalid,
  input  logic                           awready,
  output logic [ADDR_WIDTH-1:0]          awaddr,
  output logic [7:0]                     awlen,
  output logic [2:0]                     awsize,
  output logic [1:0]                     awburst,
  output logic [3:0]                     awid,
  output logic                           wvalid,
  input  logic                           wready,
  output logic [AXI_DATA_WIDTH-1:0]      wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]    wstrb,
  output logic                           wlast,
  input  logic                           bvalid,
  output logic                           bready,
  input  logic [1:0]                     bresp,
  output logic                           busy,
  output logic                           bus_err
);

  localparam int BEATS = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int OFFS  = $clog2(LINE_WIDTH / 8);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'((64'd1 << OFFS) - 64'd1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_AW = 2'd1,
    SEND_W  = 2'd2,
    WAIT_B  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic [BW-1:0]         beat;
  logic                  beat_is_last;

  logic [BEATS-1:0][AXI_DATA_WIDTH-1:0] line_beats;

  assign line_beats   = line_q;
  assign beat_is_last = (beat == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!fifo_empty)                state_next = SEND_AW;
      SEND_AW: if (awready)                    state_next = SEND_W;
      SEND_W:  if (wready && beat_is_last)     state_next = WAIT_B;
      WAIT_B:  if (bvalid)                     state_next = IDLE;
      default:                                 state_next = IDLE;
    endcase
  end

  // Pop is gated by rst so a reset cycle never consumes an entry.
  always_comb begin
    fifo_pop = 1'b0;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    wlast    = 1'b0;
    bready   = 1'b0;
    busy     = 1'b1;
    unique case (state)
      IDLE: begin
        fifo_pop = !fifo_empty && !rst;
        busy     = 1'b0;
      end
      SEND_AW: awvalid = 1'b1;
      SEND_W: begin
        wvalid = 1'b1;
        wlast  = beat_is_last;
      end
      WAIT_B:  bready = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // The captured entry and beat index only move at handshakes, keeping awaddr/wdata stable under stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      line_q  <= '0;
      beat    <= '0;
      bus_err <= 1'b0;
    end else begin
      if (fifo_pop) begin
        addr_q <= fifo_data[ADDR_WIDTH+LINE_WIDTH-1 -: ADDR_WIDTH];
        line_q <= fifo_data[LINE_WIDTH-1:0];
      end
      if (state == SEND_AW && awready) begin
        beat <= '0;
      end else if (state == SEND_W && wready && !beat_is_last) begin
        beat <= beat + 1'b1;
      end
      if (state == WAIT_B && bvalid && bresp != 2'b00) begin
        bus_err <= 1'b1;
      end
    end
  end

  assign awaddr  = addr_q & ~OFFS_MASK;
  assign wdata   = line_beats[beat];
  assign awlen   = 8'(BEATS - 1);
  assign awsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign awburst = 2'b01;
  assign awid    = 4'(AXI_ID);
  assign wstrb   = '1;

endmodule

// File: tb/tb_fifo_axi_drain.sv
// Directed bench for fifo_axi_drain: a queue models the source FIFO, and expected AW/W
// traffic is pushed at each pop and checked as the DUT completes handshakes.
module tb_fifo_axi_drain;

  localparam int AW    = 32;
  localparam int LW    = 128;
  localparam int DW    = 32;
  localparam int BEATS = LW / DW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            fifo_empty;
  logic [AW+LW-1:0] fifo_data;
  logic            fifo_pop;
  logic            awvalid, awready;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [3:0]      awid;
  logic            wvalid, wready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            bvalid, bready;
  logic [1:0]      bresp;
  logic            busy, bus_err;

  fifo_axi_drain #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .AXI_DATA_WIDTH(DW), .AXI_ID(0)) dut (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .busy(busy), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  logic [AW+LW-1:0] src[$];
  logic [AW-1:0]    exp_aw[$];
  logic [DW:0]      exp_w[$];
  int pop_cycles[$];
  int aw_cycles[$];
  int w_cycles[$];
  int b_cycles[$];
  int rise_cyc = -1;

  logic prev_pop, prev_b, prev_aw_stall, prev_w_stall, prev_bus_err, aw_done;
  logic [AW-1:0] prev_awaddr;
  logic [DW-1:0] prev_wdata;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic awr, input logic wr, input logic bv, input logic [1:0] br);
    awready = awr;
    wready  = wr;
    bvalid  = bv;
    bresp   = br;
  endtask

  task automatic clearModel();
    src.delete();
    exp_aw.delete();
    exp_w.delete();
    prev_pop = 1'b0; prev_b = 1'b0; prev_aw_stall = 1'b0; prev_w_stall = 1'b0;
    prev_bus_err = 1'b0; aw_done = 1'b0;
    prev_awaddr = '0; prev_wdata = '0;
  endtask

  // Protocol monitor and scoreboard, evaluated once per cycle while outputs are settled.
  task automatic monitor();
    logic [AW+LW-1:0] e;
    logic [DW:0]      w;
    if (fifo_pop) begin
      checkOutput("pop_nonempty", fifo_empty, 1'b0);
      checkOutput("pop_not_busy", busy, 1'b0);
      e = src.pop_front();
      exp_aw.push_back({e[AW+LW-1:LW+4], 4'h0});
      for (int b = 0; b < BEATS; b++) exp_w.push_back({b == BEATS - 1, e[b*DW +: DW]});
      pop_cycles.push_back(cyc);
    end
    if (prev_pop) begin
      checkOutput("busy_after_pop", busy, 1'b1);
      checkOutput("aw_after_pop", awvalid, 1'b1);
    end
    if (prev_b) checkOutput("idle_after_b", busy, 1'b0);
    if (prev_aw_stall) begin
      checkOutput("aw_hold_valid", awvalid, 1'b1);
      checkOutput("aw_hold_addr", awaddr, prev_awaddr);
    end
    if (prev_w_stall) begin
      checkOutput("w_hold_valid", wvalid, 1'b1);
      checkOutput("w_hold_data", wdata, prev_wdata);
    end
    if (wvalid) checkOutput("w_after_aw", aw_done, 1'b1);
    if (awvalid && awready) begin
      checkOutput("aw_expected", exp_aw.size() != 0, 1'b1);
      if (exp_aw.size() != 0) checkOutput("awaddr", awaddr, exp_aw.pop_front());
      checkOutput("awlen", awlen, 8'd3);
      aw_done = 1'b1;
      aw_cycles.push_back(cyc);
    end
    if (wvalid && wready) begin
      checkOutput("w_expected", exp_w.size() != 0, 1'b1);
      if (exp_w.size() != 0) begin
        w = exp_w.pop_front();
        checkOutput("wdata", wdata, w[DW-1:0]);
        checkOutput("wlast", wlast, w[DW]);
      end
      w_cycles.push_back(cyc);
    end
    if (bready && bvalid) begin
      aw_done = 1'b0;
      b_cycles.push_back(cyc);
    end
    if (!prev_bus_err && bus_err) rise_cyc = cyc;
    prev_pop      = fifo_pop;
    prev_b        = bready && bvalid;
    prev_aw_stall = awvalid && !awready;
    prev_w_stall  = wvalid && !wready;
    prev_awaddr   = awaddr;
    prev_wdata    = wdata;
    prev_bus_err  = bus_err;
  endtask

  task automatic cycle();
    fifo_empty = (src.size() == 0);
    fifo_data  = fifo_empty ? '0 : src[0];
    #1;
    if (rst) clearModel();
    else     monitor();
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int p, wb, bb, ab, pb;
    logic [AW+LW-1:0] e1, e2, e3;
    e1 = {32'h1000_0004, 128'h44444444_33333333_22222222_11111111};
    e2 = {32'h2000_0010, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA};
    e3 = {32'h3000_003C, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0};
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    fifo_empty = 1'b1;
    fifo_data  = '0;
    clearModel();
    repeat (3) @(negedge clk);

    // reset state
    checkOutput("rst_fifo_pop", fifo_pop, 1'b0);
    checkOutput("rst_awvalid", awvalid, 1'b0);
    checkOutput("rst_wvalid", wvalid, 1'b0);
    checkOutput("rst_wlast", wlast, 1'b0);
    checkOutput("rst_bready", bready, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_bus_err", bus_err, 1'b0);
    checkOutput("rst_awaddr", awaddr, 32'h0);
    checkOutput("rst_wdata", wdata, 32'h0);
    checkOutput("rst_awlen", awlen, 8'd3);
    checkOutput("rst_awsize", awsize, 3'd2);
    checkOutput("rst_awburst", awburst, 2'b01);
    checkOutput("rst_awid", awid, 4'd0);
    checkOutput("rst_wstrb", wstrb, 4'hF);
    rst = 1'b0;
    repeat (2) cycle();

    // single entry, no stalls
    $display("[TB] single entry");
    wb = w_cycles.size(); ab = aw_cycles.size(); bb = b_cycles.size(); pb = pop_cycles.size();
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b00);
    src.push_back(e1);
    repeat (9) cycle();
    checkOutput("t1_pops", pop_cycles.size() - pb, 1);
    p = pop_cycles[pb];
    checkOutput("t1_aw_cycle", aw_cycles[ab] - p, 1);
    checkOutput("t1_w0_cycle", w_cycles[wb] - p, 2);
    checkOutput("t1_w3_cycle", w_cycles[wb+3] - p, 5);
    checkOutput("t1_b_cycle", b_cycles[bb] - p, 6);
    checkOutput("t1_sb_drained", exp_w.size() + exp_aw.size(), 0);

    // two entries back-to-back
    $display("[TB] back-to-back");
    ab = aw_cycles.size(); bb = b_cycles.size(); pb = pop_cycles.size();
    src.push_back(e2);
    src.push_back(e3);
    repeat (16) cycle();
    checkOutput("t2_pops", pop_cycles.size() - pb, 2);
    checkOutput("t2_pop_spacing", pop_cycles[pb+1] - pop_cycles[pb], 7);
    checkOutput("t2_aw2_after_b1", aw_cycles[ab+1] > b_cycles[bb], 1'b1);
    checkOutput("t2_sb_drained", exp_w.size() + exp_aw.size(), 0);

    // stalls on AW and W
    $display("[TB] stalls");
    wb = w_cycles.size(); ab = aw_cycles.size(); pb = pop_cycles.size();
    src.push_back(e1);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(i > 5, i[0], 1'b1, 2'b00);
      cycle();
    end
    checkOutput("t3_aw_cycle", aw_cycles[ab] - pop_cycles[pb], 6);
    checkOutput("t3_w_handshakes", w_cycles.size() - wb, 4);
    checkOutput("t3_sb_drained", exp_w.size() + exp_aw.size(), 0);

    // error response then OKAY
    $display("[TB] bus error");
    checkOutput("t4_err_clear_before", bus_err, 1'b0);
    bb = b_cycles.size();
    src.push_back(e2);
    src.push_back(e3);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, (b_cycles.size() == bb) ? 2'b10 : 2'b00);
      cycle();
    end
    checkOutput("t4_b_count", b_cycles.size() - bb, 2);
    checkOutput("t4_err_rise", rise_cyc - b_cycles[bb], 1);
    checkOutput("t4_err_sticky", bus_err, 1'b1);

    // reset during beat 2
    $display("[TB] reset mid-burst");
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b00);
    src.push_back(e2);
    repeat (4) cycle();
    checkOutput("t5_in_w", wvalid, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checkOutput("t5_wvalid", wvalid, 1'b0);
    checkOutput("t5_awvalid", awvalid, 1'b0);
    checkOutput("t5_bready", bready, 1'b0);
    checkOutput("t5_busy", busy, 1'b0);
    checkOutput("t5_bus_err", bus_err, 1'b0);
    wb = w_cycles.size();
    src.push_back(e3);
    repeat (9) cycle();
    checkOutput("t5_w_handshakes", w_cycles.size() - wb, 4);
    checkOutput("t5_sb_drained", exp_w.size() + exp_aw.size(), 0);

    // empty FIFO held
    $display("[TB] empty fifo");
    for (int i = 0; i < 20; i++) begin
      cycle();
      checkOutput("t6_pop", fifo_pop, 1'b0);
      checkOutput("t6_awvalid", awvalid, 1'b0);
      checkOutput("t6_busy", busy, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
